// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants and channel encoding for the 1-to-2 buffered demux
package demux_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_DEPTH  = 4;

    typedef enum logic {
        CH1 = 1'b0,
        CH2 = 1'b1
    } ch_e;

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through fifo with occupancy counter and async reset
module sync_fifo
    import demux_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_depth_check
        $error("sync_fifo: DEPTH must be a power of 2 and at least 2");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    // A full fifo refuses pushes even when popping on the same edge.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign empty = (count == '0);
    assign full  = (count == FULL_LEVEL);
    assign level = count;
    assign dout  = empty ? '0 : mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is never cleared; stale entries are hidden because dout is gated by empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

endmodule

// File: rtl/demux1_2_buf.sv
// rtl/demux1_2_buf.sv - routes one input stream into two buffered output channels by tag
module demux1_2_buf
    import demux_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_W-1:0]        out1_data,
    output logic                     out1_valid,
    input  logic                     out1_ready,
    output logic [$clog2(DEPTH):0]   out1_level,
    output logic [DATA_W-1:0]        out2_data,
    output logic                     out2_valid,
    input  logic                     out2_ready,
    output logic [$clog2(DEPTH):0]   out2_level
);

    logic full1;
    logic full2;
    logic empty1;
    logic empty2;
    logic push1;
    logic push2;
    logic pop1;
    logic pop2;

    // Only the addressed channel's fullness gates the input; head-of-line blocking is intended.
    assign in_ready = (in_sel == CH2) ? ~full2 : ~full1;

    assign push1 = in_valid & in_ready & (in_sel == CH1);
    assign push2 = in_valid & in_ready & (in_sel == CH2);

    assign out1_valid = ~empty1;
    assign out2_valid = ~empty2;
    assign pop1       = out1_valid & out1_ready;
    assign pop2       = out2_valid & out2_ready;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo1 (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .push  (push1),
        .pop   (pop1),
        .din   (in_data),
        .dout  (out1_data),
        .empty (empty1),
        .full  (full1),
        .level (out1_level)
    );

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo2 (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .push  (push2),
        .pop   (pop2),
        .din   (in_data),
        .dout  (out2_data),
        .empty (empty2),
        .full  (full2),
        .level (out2_level)
    );

endmodule
